// File: rtl/rv_pkg.sv
// Shared definitions for the multicycle control sequencer: major-opcode
// constants, state encoding and trap-cause codes.
package rv_pkg;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_LOAD_FP  = 5'b00001;
    localparam logic [4:0] OPC_CUSTOM_0 = 5'b00010;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6,
        S_COP    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } cause_t;

    // Instruction classes whose ALU operand B comes from the immediate.
    function automatic logic opc_uses_imm(input logic [4:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE) || (opc == OPC_OP_IMM);
    endfunction

endpackage

// File: rtl/rv_wait_timer.sv
// Bus wait counter: counts cycles spent waiting for an acknowledge and flags
// a timeout when the MEM_TIMEOUT-th waiting cycle passes without one.
// An ack in that same cycle wins over the timeout.
module rv_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

    logic [7:0] count;

    // Count idle waiting cycles; any non-waiting cycle or ack restarts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (!active || ack) begin
            count <= 8'd0;
        end else begin
            count <= count + 8'd1;
        end
    end

    assign expired = active && !ack && (count == LAST);

endmodule

// File: rtl/rv_ctrl_fsm.sv
// Multicycle control sequencer: fetch, decode by major opcode, sequence data
// memory / ALU-source / register-file write controls, sticky trap on illegal
// opcode or bus timeout.
// Optional macro RV_CUSTOM0_EN: routes CUSTOM_0 to a coprocessor handshake
// state (cop_req/cop_ack); without it CUSTOM_0 is an illegal opcode.
// The store retire pulse is qualified by dmem_ack so a store retires in its
// ack cycle; every other output depends only on registered state and ir.
module rv_ctrl_fsm
    import rv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             alu_b_imm,
    output logic             imm_s,
    output logic             rf_we,
    output logic             rf_wsel,
    output logic             pc_inc,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state_dbg
`ifdef RV_CUSTOM0_EN
    ,
    output logic             cop_req,
    input  logic             cop_ack
`endif
);

    state_t     state;
    state_t     next_state;
    cause_t     next_cause;
    logic [4:0] opc;
    logic       wait_active;
    logic       wait_ack;
    logic       timeout;

    assign opc         = ir[6:2];
    assign state_dbg   = state;
    assign wait_active = (state == S_FETCH) || (state == S_MEM) || (state == S_COP);

    // Select the acknowledge that belongs to the current waiting state; acks
    // arriving in any other state are ignored.
    always_comb begin
        wait_ack = 1'b0;
        case (state)
            S_FETCH: wait_ack = imem_ack;
            S_MEM:   wait_ack = dmem_ack;
`ifdef RV_CUSTOM0_EN
            S_COP:   wait_ack = cop_ack;
`endif
            default: wait_ack = 1'b0;
        endcase
    end

    rv_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (wait_active),
        .ack    (wait_ack),
        .expired(timeout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RST;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, including the cause recorded when entering the trap.
    always_comb begin
        next_state = state;
        next_cause = CAUSE_NONE;
        case (state)
            S_RST: next_state = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    next_state = S_DECODE;
                end else if (timeout) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (ir[1:0] != 2'b11) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_ILLEGAL;
                end else begin
                    case (opc)
                        OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: next_state = S_EXEC;
                        OPC_MISC_MEM: next_state = S_FETCH;
`ifdef RV_CUSTOM0_EN
                        OPC_CUSTOM_0: next_state = S_COP;
`else
                        OPC_CUSTOM_0: begin
                            next_state = S_TRAP;
                            next_cause = CAUSE_ILLEGAL;
                        end
`endif
                        OPC_LOAD_FP: begin
                            next_state = S_TRAP;
                            next_cause = CAUSE_ILLEGAL;
                        end
                        default: begin
                            next_state = S_TRAP;
                            next_cause = CAUSE_ILLEGAL;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                if ((opc == OPC_LOAD) || (opc == OPC_STORE)) begin
                    next_state = S_MEM;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    next_state = (opc == OPC_STORE) ? S_FETCH : S_WB;
                end else if (timeout) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_WB:   next_state = S_FETCH;
            S_TRAP: next_state = S_TRAP;
            S_COP: begin
`ifdef RV_CUSTOM0_EN
                if (cop_ack) begin
                    next_state = S_WB;
                end else if (timeout) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
`else
                next_state = S_TRAP;
                next_cause = CAUSE_ILLEGAL;
`endif
            end
            default: next_state = S_RST;
        endcase
    end

    // Instruction register, retired count and sticky trap bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir         <= 32'd0;
            instret    <= '0;
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
        end else begin
            if ((state == S_FETCH) && imem_ack) begin
                ir <= imem_rdata;
            end
            if (pc_inc) begin
                instret <= instret + CNT_W'(1);
            end
            if ((next_state == S_TRAP) && (state != S_TRAP)) begin
                trap       <= 1'b1;
                trap_cause <= next_cause;
            end
        end
    end

    // Control outputs decoded from the current state and latched instruction.
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        alu_b_imm = 1'b0;
        imm_s     = 1'b0;
        rf_we     = 1'b0;
        rf_wsel   = 1'b0;
        pc_inc    = 1'b0;
`ifdef RV_CUSTOM0_EN
        cop_req   = 1'b0;
`endif
        case (state)
            S_FETCH: imem_req = 1'b1;
            S_DECODE: begin
                pc_inc = (ir[1:0] == 2'b11) && (opc == OPC_MISC_MEM);
            end
            S_EXEC: begin
                alu_b_imm = opc_uses_imm(opc);
                imm_s     = (opc == OPC_STORE);
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                dmem_we   = (opc == OPC_STORE);
                alu_b_imm = opc_uses_imm(opc);
                imm_s     = (opc == OPC_STORE);
                pc_inc    = (opc == OPC_STORE) && dmem_ack;
            end
            S_WB: begin
                rf_we   = (ir[11:7] != 5'd0);
                rf_wsel = (opc == OPC_LOAD);
                pc_inc  = 1'b1;
            end
`ifdef RV_CUSTOM0_EN
            S_COP: cop_req = 1'b1;
`endif
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_rv_ctrl_fsm.sv
// Self-checking bench for rv_ctrl_fsm (default build, RV_CUSTOM0_EN undefined).
// Table of instruction vectors with hand-derived expectations, applied through
// a scoreboard queue, plus a hand-written reset-during-access sequence.
module tb_rv_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] ir;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack = 1'b0;
    logic        alu_b_imm;
    logic        imm_s;
    logic        rf_we;
    logic        rf_wsel;
    logic        pc_inc;
    logic [31:0] instret;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int expInstret = 0;

    typedef struct {
        logic [31:0] instr;
        int          fd;
        int          md;
        bit          spur;
        int          lat;
        bit          trap;
        logic [1:0]  cause;
        bit          rfwe;
        bit          wsel;
        bit          mem;
        bit          dwe;
        bit          imms;
        bit          exe;
        bit          bimm;
    } vec_t;

    vec_t retireVecs[$];
    vec_t trapVecs[$];
    vec_t sbq[$];

    rv_ctrl_fsm #(
        .MEM_TIMEOUT(15),
        .CNT_W(32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .ir        (ir),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack),
        .alu_b_imm (alu_b_imm),
        .imm_s     (imm_s),
        .rf_we     (rf_we),
        .rf_wsel   (rf_wsel),
        .pc_inc    (pc_inc),
        .instret   (instret),
        .trap      (trap),
        .trap_cause(trap_cause),
        .state_dbg (state_dbg)
    );

    // Free-running core clock.
    always #5 clk = ~clk;

    // Hard stop in case something upstream never returns.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(logic [31:0] instr, int fd, int md, bit spur, int lat,
                                bit trp, logic [1:0] cause, bit rfwe, bit wsel, bit mem,
                                bit dwe, bit imms, bit exe, bit bimm);
        vec_t v;
        v.instr = instr; v.fd = fd; v.md = md; v.spur = spur; v.lat = lat;
        v.trap = trp; v.cause = cause; v.rfwe = rfwe; v.wsel = wsel; v.mem = mem;
        v.dwe = dwe; v.imms = imms; v.exe = exe; v.bimm = bimm;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, release and
    // follow S_RST into S_FETCH. Returns at posedge+1 of the first fetch cycle.
    task automatic resetDut(input string tag);
        rst_n = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #1;
        checkOutput({tag, ".rst.state"}, 32'(state_dbg), 32'd0);
        checkOutput({tag, ".rst.imem_req"}, 32'(imem_req), 32'd0);
        checkOutput({tag, ".rst.dmem_req"}, 32'(dmem_req), 32'd0);
        checkOutput({tag, ".rst.trap"}, {trap_cause, 29'd0, trap}, 32'd0);
        checkOutput({tag, ".rst.instret"}, instret, 32'd0);
        checkOutput({tag, ".rst.ir"}, ir, 32'd0);
        checkOutput({tag, ".rst.strobes"},
                    32'({pc_inc, rf_we, rf_wsel, alu_b_imm, imm_s, dmem_we}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput({tag, ".rel.state"}, 32'(state_dbg), 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, ".fetch.state"}, 32'(state_dbg), 32'd1);
        checkOutput({tag, ".fetch.imem_req"}, 32'(imem_req), 32'd1);
        checkOutput({tag, ".fetch.instret"}, instret, 32'd0);
        expInstret = 0;
    endtask

    // Act as instruction and data memory for one instruction, observe the
    // control outputs, then compare against the scoreboard entry.
    task automatic applyStimulus(input vec_t v, input string tag);
        vec_t exp;
        int   cyc = 0;
        int   fcnt = 0;
        int   dcnt = 0;
        int   lat = -1;
        bit   done = 0;
        bit   trapSeen = 0;
        logic [1:0] causeSeen = 2'b00;
        bit   rfweRet = 0, wselRet = 0, rfweEver = 0;
        bit   memSeen = 0, dweMin = 1, dweMax = 0, immsSeen = 0, bimmSeen = 0;
        int   busy = 0;

        sbq.push_back(v);
        while (!done && cyc < 80) begin
            cyc++;
            imem_ack   = 1'b0;
            dmem_ack   = 1'b0;
            imem_rdata = 32'hFFFF_FFFF;
            if (imem_req) begin
                if (fcnt == v.fd) begin
                    imem_ack   = 1'b1;
                    imem_rdata = v.instr;
                end
                fcnt++;
            end else if (v.spur) begin
                imem_ack = 1'b1;
            end
            if (dmem_req) begin
                if (dcnt == v.md) dmem_ack = 1'b1;
                dcnt++;
            end else if (v.spur) begin
                dmem_ack = 1'b1;
            end
            #1;
            if (state_dbg == 3'd3) bimmSeen = alu_b_imm;
            if (dmem_req) begin
                memSeen = 1;
                dweMin &= dmem_we;
                dweMax |= dmem_we;
                immsSeen |= imm_s;
            end
            if (rf_we) rfweEver = 1;
            if (pc_inc) begin
                lat = cyc; rfweRet = rf_we; wselRet = rf_wsel; done = 1;
            end
            if (trap) begin
                lat = cyc; trapSeen = 1; causeSeen = trap_cause; done = 1;
            end
            @(posedge clk);
            #1;
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;

        if (!done) begin
            checkOutput({tag, ".budget"}, 32'(cyc), 32'd0);
        end
        if (sbq.size() == 0) begin
            checkOutput({tag, ".sb_empty"}, 32'd0, 32'd1);
            return;
        end
        exp = sbq.pop_front();

        checkOutput({tag, ".trap"}, 32'(trapSeen), 32'(exp.trap));
        checkOutput({tag, ".latency"}, 32'(lat), 32'(exp.lat));
        if (exp.trap) begin
            checkOutput({tag, ".cause"}, 32'(causeSeen), 32'(exp.cause));
            if (exp.fd < 255) checkOutput({tag, ".ir_latched"}, ir, exp.instr);
            for (int i = 0; i < 20; i++) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'h0050_0093;
                #1;
                busy += int'(imem_req) + int'(dmem_req) + int'(pc_inc) + int'(rf_we);
                @(posedge clk);
                #1;
            end
            imem_ack = 1'b0;
            checkOutput({tag, ".idle_strobes"}, 32'(busy), 32'd0);
            checkOutput({tag, ".trap_state"}, 32'(state_dbg), 32'd6);
            checkOutput({tag, ".trap_sticky"}, {trap_cause, 29'd0, trap}, {exp.cause, 29'd0, 1'b1});
            checkOutput({tag, ".instret_frozen"}, instret, 32'(expInstret));
            if (exp.fd < 255) checkOutput({tag, ".ir_frozen"}, ir, exp.instr);
        end else begin
            expInstret++;
            checkOutput({tag, ".rf_we"}, 32'(rfweRet), 32'(exp.rfwe));
            checkOutput({tag, ".rf_we_ever"}, 32'(rfweEver), 32'(exp.rfwe));
            checkOutput({tag, ".rf_wsel"}, 32'(wselRet), 32'(exp.wsel));
            checkOutput({tag, ".dmem_req"}, 32'(memSeen), 32'(exp.mem));
            if (exp.mem) begin
                checkOutput({tag, ".dmem_we_lo"}, 32'(dweMin), 32'(exp.dwe));
                checkOutput({tag, ".dmem_we_hi"}, 32'(dweMax), 32'(exp.dwe));
                checkOutput({tag, ".imm_s"}, 32'(immsSeen), 32'(exp.imms));
            end
            if (exp.exe) checkOutput({tag, ".alu_b_imm"}, 32'(bimmSeen), 32'(exp.bimm));
            checkOutput({tag, ".instret"}, instret, 32'(expInstret));
            checkOutput({tag, ".back_to_fetch"}, 32'(state_dbg), 32'd1);
        end
    endtask

    initial begin
        //                    instr         fd   md spur lat trap cause rfwe wsel mem dwe imms exe bimm
        retireVecs.push_back(mk(32'h0050_0093, 0,  0, 0,  4, 0, 2'b00, 1, 0, 0, 0, 0, 1, 1)); // addi x1
        retireVecs.push_back(mk(32'h0000_2103, 0,  3, 0,  8, 0, 2'b00, 1, 1, 1, 0, 0, 1, 1)); // lw x2
        retireVecs.push_back(mk(32'h0020_2023, 0,  0, 0,  4, 0, 2'b00, 0, 0, 1, 1, 1, 1, 1)); // sw
        retireVecs.push_back(mk(32'h0000_0013, 0,  0, 0,  4, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1)); // nop
        retireVecs.push_back(mk(32'h0000_000F, 0,  0, 0,  2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0)); // fence
        retireVecs.push_back(mk(32'h0020_81B3, 2,  0, 0,  6, 0, 2'b00, 1, 0, 0, 0, 0, 1, 0)); // add x3
        retireVecs.push_back(mk(32'h0040_2183, 1,  1, 1,  7, 0, 2'b00, 1, 1, 1, 0, 0, 1, 1)); // lw + spurious acks
        retireVecs.push_back(mk(32'h0020_2023, 0,  2, 1,  6, 0, 2'b00, 0, 0, 1, 1, 1, 1, 1)); // sw + spurious acks
        retireVecs.push_back(mk(32'h0050_0093, 14, 0, 0, 18, 0, 2'b00, 1, 0, 0, 0, 0, 1, 1)); // imem ack on last cycle
        retireVecs.push_back(mk(32'h0000_2103, 0, 14, 0, 19, 0, 2'b00, 1, 1, 1, 0, 0, 1, 1)); // dmem ack on last cycle
        retireVecs.push_back(mk(32'h0000_000F, 3,  0, 0,  5, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0)); // fence, slow fetch

        trapVecs.push_back(mk(32'h0000_0007, 0,   0, 0,  3, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0)); // LOAD_FP
        trapVecs.push_back(mk(32'h0000_0010, 0,   0, 0,  3, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0)); // ir[1:0]=00
        trapVecs.push_back(mk(32'h0000_000B, 0,   0, 0,  3, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0)); // CUSTOM_0
        trapVecs.push_back(mk(32'h0000_0077, 0,   0, 0,  3, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0)); // unknown major
        trapVecs.push_back(mk(32'h0050_0093, 255, 0, 0, 16, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0)); // imem timeout
        trapVecs.push_back(mk(32'h0000_2103, 0, 255, 0, 19, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0)); // dmem timeout

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        resetDut("init");

        for (int i = 0; i < retireVecs.size(); i++) begin
            applyStimulus(retireVecs[i], $sformatf("ret%0d", i));
        end

        // Reset while a load is waiting on the data bus.
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_2103;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        checkOutput("midrst.decode", 32'(state_dbg), 32'd2);
        @(posedge clk);
        #1;
        checkOutput("midrst.exec", 32'(state_dbg), 32'd3);
        @(posedge clk);
        #1;
        checkOutput("midrst.mem", 32'(state_dbg), 32'd4);
        checkOutput("midrst.dmem_req_before", 32'(dmem_req), 32'd1);
        #2;
        resetDut("midrst");

        for (int i = 0; i < trapVecs.size(); i++) begin
            applyStimulus(trapVecs[i], $sformatf("trap%0d", i));
            resetDut($sformatf("trap%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
